bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
Multiplexed driver for a DIGITS-wide common-anode seven-segment display. Takes a packed BCD word plus per-digit decimal points and time-multiplexes them onto one shared active-low segment bus and active-low digit selects. Adds frame-synchronous update (no tearing), anti-ghosting dead time and optional leading-zero blanking. Sits between the counter/controller logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned; must be >= 1
CLK_HZ, 50000000, clk frequency in Hz
SCAN_HZ, 1000, digit slot rate in Hz; DIV = CLK_HZ/SCAN_HZ clocks per slot, integer division; must satisfy DIV > BLANK_CYCLES
BLANK_CYCLES, 16, dead-time clocks at the start of each slot; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bcd  in  4*DIGITS  digit i = bcd[4i+3:4i]; digit 0 is rightmost/least significant
dp_n  in  DIGITS  active-low decimal point per digit
load  in  1  capture bcd/dp_n into pending registers
lz_blank  in  1  1 = suppress leading zeros (sampled live)
digit_n  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp
sel_n  out  DIGITS  active-low digit enable; at most one bit low
frame_start  out  1  one-clock pulse at start of each frame

Behaviour:
- Segment code {a..g}, active low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; codes 10-15 = 1111111 (blank).
- Reset (async): all outputs registered; digit_n=8'hFF, sel_n=all ones, frame_start=0. Slot counter cnt=0, index idx=0. Active and pending code registers = 4'hF; dp registers = 1. Pending-valid flag = 0.
- Counters: cnt runs 0..DIV-1; on DIV-1, cnt wraps to 0 and idx increments, wrapping from DIGITS-1 to 0. Frame = DIGITS*DIV clocks.
- Outputs are registered from the pre-edge (idx,cnt), so they show that state one clock later.
- Blank phase, cnt < BLANK_CYCLES: digit_n=8'hFF, sel_n=all ones.
- Drive phase, cnt >= BLANK_CYCLES: sel_n bit idx = 0, all others 1. digit_n = {seg(active[idx]), dp_act[idx]}.
- frame_start = registered (idx==0 && cnt==0). The first pulse occurs in the clock after the first edge following reset release.
- load=1 at an edge: pending <= bcd/dp_n and valid <= 1. A later load before the boundary overwrites pending; last one wins.
- Frame boundary is the edge where idx==0 && cnt==0 is evaluated. If valid: active <= pending and valid <= 0.
- load on the boundary edge itself: bcd/dp_n go straight to active, are shown that frame, and valid <= 0.
- Leading-zero blanking, lz_blank=1: digit i (i >= 1) is blanked if active[j] is 0 or >= 10 for every j from i to DIGITS-1. Blanked means segments 1111111. Digit 0 is never blanked. dp still follows dp_act.
- DIGITS=1: idx stays 0; lz_blank has no effect.

Optional Feature:
Macro BCD_SCAN_BLINK_EN.
- Defined:
  - Adds parameter BLINK_FRAMES (default 256) and port blink_mask (in, DIGITS).
  - blink_mask is captured with load into pending and transferred at the boundary, identical to dp_n. Reset value is 0.
  - A frame counter toggles blink_phase every BLINK_FRAMES frame boundaries. blink_phase resets to 1 (on).
  - When blink_phase=0, digits with their active mask bit set output digit_n=8'hFF during drive; sel_n is unchanged.
- Undefined: no port, no counter; behaviour as above.

Test Plan:
DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2.
1. Reset held then released -> digit_n=8'hFF and sel_n=4'b1111 during reset. After release, frame_start pulses every 40 clocks; digit_n stays 8'hFF in drive phases (blank active codes).
2. load bcd=16'h1234, dp_n=4'b1011 mid-frame -> display unchanged until next frame_start. Slot 0: 2 blank clocks, then 8 clocks sel_n=4'b1110, digit_n=8'b10011001. Slot 2: sel_n=4'b1011, digit_n=8'b00100100.
3. bcd=16'h0070, dp_n=4'hF, lz_blank=1 -> digits 3 and 2 show 8'hFF; digit 1 shows 8'b00011111; digit 0 shows 8'b00000011. With lz_blank=0, digits 3 and 2 show 8'b00000011.
4. bcd=16'h0000, lz_blank=1 -> only digit 0 shows 8'b00000011. Load 16'h5678 on the boundary edge -> shown that same frame.
5. Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows 2222 only. Drop rst_n mid-drive -> outputs all ones immediately, before the next clk edge.
6. With BCD_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 on for 2 frames, 8'hFF for 2 frames, repeating; digits 1-3 unaffected.

Source files
------------

// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Multiplexed common-anode 7-segment driver with frame-synchronous
//            update, dead-time blanking and leading-zero suppression.
//            Optional blinking enabled by defining BCD_SCAN_BLINK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_scan_display #(
    parameter int DIGITS       = 4,
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
`ifdef BCD_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_n,
    input  logic                  load,
    input  logic                  lz_blank,
`ifdef BCD_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [7:0]            digit_n,
    output logic [DIGITS-1:0]     sel_n,
    output logic                  frame_start
);

    localparam int C_DIV   = CLK_HZ / SCAN_HZ;
    localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int C_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_IDX_W-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_act;
    logic [4*DIGITS-1:0] r_pend;
    logic [DIGITS-1:0]   r_dp_act;
    logic [DIGITS-1:0]   r_dp_pend;
    logic                r_valid;

    logic                w_bound;
    logic                w_slot_end;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_code;
    logic                w_dp;
    logic                w_lz_hit;
    logic [DIGITS-1:0]   w_sel;
    logic                w_blink_off;

`ifdef BCD_SCAN_BLINK_EN
    localparam int C_FCNT_W = $clog2(BLINK_FRAMES + 1);

    logic [C_FCNT_W-1:0] r_fcnt;
    logic                r_phase;
    logic [DIGITS-1:0]   r_mask_act;
    logic [DIGITS-1:0]   r_mask_pend;
    logic                w_mask;
`endif

    function automatic logic [6:0] f_seg(input logic [3:0] code);
        case (code)
            4'd0:    f_seg = 7'b0000001;
            4'd1:    f_seg = 7'b1001111;
            4'd2:    f_seg = 7'b0010010;
            4'd3:    f_seg = 7'b0000110;
            4'd4:    f_seg = 7'b1001100;
            4'd5:    f_seg = 7'b0100100;
            4'd6:    f_seg = 7'b0100000;
            4'd7:    f_seg = 7'b0001111;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0000100;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    assign w_bound    = (r_idx == '0) && (r_cnt == '0);
    assign w_slot_end = (r_cnt == C_CNT_W'(C_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_W'(DIGITS - 1)) ? '0 : r_idx + C_IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end
    end

    // A load coinciding with the frame boundary bypasses pending so it is
    // visible in the frame that starts on that very edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act     <= '1;
            r_pend    <= '1;
            r_dp_act  <= '1;
            r_dp_pend <= '1;
            r_valid   <= 1'b0;
`ifdef BCD_SCAN_BLINK_EN
            r_mask_act  <= '0;
            r_mask_pend <= '0;
`endif
        end else if (load && w_bound) begin
            r_act    <= bcd;
            r_dp_act <= dp_n;
            r_valid  <= 1'b0;
`ifdef BCD_SCAN_BLINK_EN
            r_mask_act <= blink_mask;
`endif
        end else begin
            if (w_bound && r_valid) begin
                r_act    <= r_pend;
                r_dp_act <= r_dp_pend;
                r_valid  <= 1'b0;
`ifdef BCD_SCAN_BLINK_EN
                r_mask_act <= r_mask_pend;
`endif
            end
            if (load) begin
                r_pend    <= bcd;
                r_dp_pend <= dp_n;
                r_valid   <= 1'b1;
`ifdef BCD_SCAN_BLINK_EN
                r_mask_pend <= blink_mask;
`endif
            end
        end
    end

`ifdef BCD_SCAN_BLINK_EN
    // Counter runs 1..BLINK_FRAMES so the first frame after reset counts fully.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_bound) begin
            if (r_fcnt == C_FCNT_W'(BLINK_FRAMES)) begin
                r_fcnt  <= C_FCNT_W'(1);
                r_phase <= ~r_phase;
            end else begin
                r_fcnt <= r_fcnt + C_FCNT_W'(1);
            end
        end
    end
`endif

    // A digit is a leading zero when it and every more-significant digit is
    // zero or non-decimal; digit 0 always shows.
    always_comb begin : p_lead_zero
        logic l_run;
        l_run = 1'b1;
        w_lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            l_run = l_run && ((r_act[4*i +: 4] == 4'd0) || (r_act[4*i +: 4] >= 4'd10));
            if (i != 0) begin
                w_lz[i] = l_run;
            end
        end
    end

    always_comb begin
        w_code   = 4'hF;
        w_dp     = 1'b1;
        w_lz_hit = 1'b0;
        w_sel    = '1;
`ifdef BCD_SCAN_BLINK_EN
        w_mask   = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == C_IDX_W'(i)) begin
                w_code   = r_act[4*i +: 4];
                w_dp     = r_dp_act[i];
                w_lz_hit = w_lz[i];
                w_sel[i] = 1'b0;
`ifdef BCD_SCAN_BLINK_EN
                w_mask   = r_mask_act[i];
`endif
            end
        end
    end

`ifdef BCD_SCAN_BLINK_EN
    assign w_blink_off = !r_phase && w_mask;
`else
    assign w_blink_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_n     <= 8'hFF;
            sel_n       <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_bound;
            if (r_cnt < C_CNT_W'(BLANK_CYCLES)) begin
                digit_n <= 8'hFF;
                sel_n   <= '1;
            end else begin
                sel_n <= w_sel;
                if (w_blink_off) begin
                    digit_n <= 8'hFF;
                end else begin
                    digit_n <= {(lz_blank && w_lz_hit) ? 7'h7F : f_seg(w_code), w_dp};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// ============================================================================
// Module   : tb_bcd_scan_display
// Brief    : Randomized self-checking bench for bcd_scan_display against a
//            frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [15:0] bcd      = 16'h0;
    logic [3:0]  dp_n     = 4'hF;
    logic        load     = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  digit_n;
    logic [3:0]  sel_n;
    logic        frame_start;
`ifdef BCD_SCAN_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif

    bcd_scan_display #(
        .DIGITS(DIGITS), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_n(dp_n), .load(load),
        .lz_blank(lz_blank),
`ifdef BCD_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .digit_n(digit_n), .sel_n(sel_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int e      = 0;
    int last_p = 0;
    logic [15:0] m_latest, m_shown;
    logic [3:0]  m_dp_latest, m_dp_shown;
    logic [7:0]  exp_d;
    logic [3:0]  exp_s;
    logic        exp_f;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] ref_digit(input int slot, input logic [15:0] v,
                                             input logic [3:0] d, input bit lz);
        bit blank;
        int c;
        blank = 1'b0;
        if (lz && slot >= 1) begin
            blank = 1'b1;
            for (int j = slot; j < DIGITS; j++) begin
                c = int'(v[4*j +: 4]);
                if (c >= 1 && c <= 9) blank = 1'b0;
            end
        end
        return {blank ? 7'h7F : ref_seg(int'(v[4*slot +: 4])), d[slot]};
    endfunction

    task automatic model_reset();
        m_latest    = 16'hFFFF;
        m_shown     = 16'hFFFF;
        m_dp_latest = 4'hF;
        m_dp_shown  = 4'hF;
        e           = 0;
    endtask

    // One clock: drive inputs, predict the registered outputs, advance the model.
    task automatic tick(input bit ld, input logic [15:0] b, input logic [3:0] d, input bit lz);
        int p, slot, c;
        load = ld; bcd = b; dp_n = d; lz_blank = lz;
        @(posedge clk);
        p = e % FRAME; slot = p / DIV; c = p % DIV;
        last_p = p;
        exp_f = (p == 0);
        if (c < BLANK) begin
            exp_d = 8'hFF;
            exp_s = 4'hF;
        end else begin
            exp_s = ~(4'b0001 << slot);
            exp_d = ref_digit(slot, m_shown, m_dp_shown, lz);
        end
        if (ld) begin m_latest = b; m_dp_latest = d; end
        if (p == 0) begin m_shown = m_latest; m_dp_shown = m_dp_latest; end
        e++;
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (digit_n !== 8'hFF) begin errors++; $display("FAIL reset_digit got=%h exp=ff", digit_n); end
        if (sel_n !== 4'hF)    begin errors++; $display("FAIL reset_sel got=%b exp=1111", sel_n); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            checks += 3;
            if (digit_n !== exp_d) begin errors++; $display("FAIL post_reset_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL post_reset_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
            if (frame_start !== exp_f) begin errors++; $display("FAIL post_reset_fs e=%0d got=%b exp=%b", e, frame_start, exp_f); end
        end
    endtask

    task automatic test_load_mid_frame();
        while (e % FRAME != 15) tick(1'b0, 16'h0, 4'hF, 1'b0);
        tick(1'b1, 16'h1234, 4'b1011, 1'b0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
            checks += 3;
            if (digit_n !== exp_d) begin errors++; $display("FAIL mid_load_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL mid_load_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
            if (frame_start !== exp_f) begin errors++; $display("FAIL mid_load_fs e=%0d got=%b exp=%b", e, frame_start, exp_f); end
            if (m_shown == 16'h1234 && last_p == 5) begin
                checks++;
                if (digit_n !== 8'b10011001 || sel_n !== 4'b1110) begin
                    errors++; $display("FAIL slot0_1234 got=%b/%b exp=10011001/1110", digit_n, sel_n);
                end
            end
            if (m_shown == 16'h1234 && last_p == 25) begin
                checks++;
                if (digit_n !== 8'b00100100 || sel_n !== 4'b1011) begin
                    errors++; $display("FAIL slot2_1234 got=%b/%b exp=00100100/1011", digit_n, sel_n);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        tick(1'b1, 16'h0070, 4'hF, 1'b1);
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), (k < 2 * FRAME));
            checks += 2;
            if (digit_n !== exp_d) begin errors++; $display("FAIL lz_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL lz_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
        end
    endtask

    task automatic test_boundary_load();
        tick(1'b1, 16'h0000, 4'hF, 1'b1);
        while (e % FRAME != 0) tick(1'b0, 16'h0, 4'hF, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            tick(1'b0, 16'h0, 4'hF, 1'b1);
            checks += 2;
            if (digit_n !== exp_d) begin errors++; $display("FAIL zero_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL zero_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
        end
        tick(1'b1, 16'h5678, 4'b0110, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b1);
            checks += 3;
            if (digit_n !== exp_d) begin errors++; $display("FAIL bnd_load_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL bnd_load_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
            if (frame_start !== exp_f) begin errors++; $display("FAIL bnd_load_fs e=%0d got=%b exp=%b", e, frame_start, exp_f); end
        end
    endtask

    task automatic test_back_to_back();
        while (e % FRAME != 5) tick(1'b0, 16'h0, 4'hF, 1'b0);
        tick(1'b1, 16'h1111, 4'hF, 1'b0);
        repeat (6) tick(1'b0, 16'h0, 4'hF, 1'b0);
        tick(1'b1, 16'h2222, 4'hE, 1'b0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
            checks += 2;
            if (digit_n !== exp_d) begin errors++; $display("FAIL b2b_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL b2b_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
        end
    endtask

    task automatic test_random();
        bit lz;
        lz = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            tick(($urandom_range(0, 24) == 0), 16'($urandom), 4'($urandom), lz);
            checks += 3;
            if (digit_n !== exp_d) begin errors++; $display("FAIL rand_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL rand_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
            if (frame_start !== exp_f) begin errors++; $display("FAIL rand_fs e=%0d got=%b exp=%b", e, frame_start, exp_f); end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 16'h8888, 4'h0, 1'b0);
        while (e % FRAME != 5) tick(1'b0, 16'h0, 4'hF, 1'b0);
        tick(1'b0, 16'h0, 4'hF, 1'b0);
        checks++;
        if (digit_n !== exp_d) begin errors++; $display("FAIL pre_async_digit got=%b exp=%b", digit_n, exp_d); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (digit_n !== 8'hFF) begin errors++; $display("FAIL async_digit got=%h exp=ff", digit_n); end
        if (sel_n !== 4'hF)    begin errors++; $display("FAIL async_sel got=%b exp=1111", sel_n); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL async_fs got=%b exp=0", frame_start); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < FRAME + 5; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
            checks += 3;
            if (digit_n !== exp_d) begin errors++; $display("FAIL rearm_digit e=%0d got=%b exp=%b", e, digit_n, exp_d); end
            if (sel_n !== exp_s) begin errors++; $display("FAIL rearm_sel e=%0d got=%b exp=%b", e, sel_n, exp_s); end
            if (frame_start !== exp_f) begin errors++; $display("FAIL rearm_fs e=%0d got=%b exp=%b", e, frame_start, exp_f); end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_leading_zero();
        test_boundary_load();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
